fifo_burst_reader: RTL

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

---
 rtl/fifo_burst_reader.sv | 108 ++++++++++
 1 files changed

// File: rtl/fifo_burst_reader.sv
// Purpose : pops bursts of up to BURST_LEN words from a FIFO into a registered valid/ready stream.
// Latency : 1 cycle from FIFO pop to m_valid; a burst starts on a word_count threshold or after TIMEOUT idle cycles.
// Backpres: m_ready=0 with m_valid=1 holds m_data/m_last and blocks further pops.
//
// Ports:
//   clk, reset_n        single clock, asynchronous active-low reset
//   empty, word_count   FIFO status (occupancy is ADDRESS_WIDTH+1 bits)
//   r_data, read        FIFO head word (show-ahead) and pop strobe
//   m_data, m_valid,
//   m_ready, m_last     output stream; m_last flags the final word of a burst
//   busy                high while a burst is in progress
module fifo_burst_reader #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int BURST_LEN     = 4,
  parameter int TIMEOUT       = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   empty,
  input  logic [ADDRESS_WIDTH:0] word_count,
  input  logic [DATA_WIDTH-1:0]  r_data,
  output logic                   read,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   busy
);

  localparam int CW = ADDRESS_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] BURST_LEN_C = CW'(BURST_LEN);
  localparam logic [CW-1:0] ONE_C       = CW'(1);
  localparam logic [TW-1:0] TIMEOUT_C   = TW'(TIMEOUT);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          state;
  logic [TW-1:0]   idle_timer;
  logic [CW-1:0]   remaining;
  logic            at_threshold;
  logic            timed_out;
  logic            accept;

  assign at_threshold = (word_count >= BURST_LEN_C);
  // A partial burst is flushed only if there is something to flush.
  assign timed_out    = (idle_timer == TIMEOUT_C) && !empty;
  assign accept       = m_valid && m_ready;

  // Pop whenever the output register is free or being drained this cycle,
  // which gives one word per cycle under continuous m_ready.
  assign read = (state == BURST) && (remaining != '0) && !empty &&
                (!m_valid || m_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      idle_timer <= '0;
      remaining  <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (at_threshold || timed_out) begin
            state      <= BURST;
            busy       <= 1'b1;
            idle_timer <= '0;
            // Burst length is latched here; later writes do not extend it.
            remaining  <= at_threshold ? BURST_LEN_C : word_count;
          end else if (empty) begin
            idle_timer <= '0;
          end else if (idle_timer != TIMEOUT_C) begin
            idle_timer <= idle_timer + 1'b1;
          end
        end
        BURST: begin
          idle_timer <= '0;
          if (accept && m_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (read) begin
        m_data    <= r_data;
        m_valid   <= 1'b1;
        m_last    <= (remaining == ONE_C);
        remaining <= remaining - ONE_C;
      end else if (accept) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule
